miriscv_mem_arbiter: RTL and testbench

- Shares one core-side memory port between the fetch unit's instruction interface and the LSU data interface.
- Arbitrates each cycle and forwards the winning request to memory.
- Tracks outstanding transactions in an in-order source-ID FIFO and routes each response back to its issuer.
- Sits between the core top (fetch stage, LSU) and the single-port memory/bus.

---
 rtl/miriscv_pkg.sv | 11 +
 rtl/miriscv_id_fifo.sv | 67 ++++++
 rtl/miriscv_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_miriscv_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_pkg.sv
// Shared types for the core memory-side blocks.
package miriscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_e;

endpackage

// File: rtl/miriscv_id_fifo.sv
// Small in-order FIFO with occupancy tracking; holds the issuer IDs of
// outstanding memory transactions.
module miriscv_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU; responses are
// steered back to their issuer via an in-order ID FIFO.
module miriscv_mem_arbiter
  import miriscv_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned DATA_PRIO   = 1
) (
  input  logic              clk_i,
  input  logic              arstn_i,

  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,

  output logic              err_o
);

  mem_src_e   winner;
  mem_src_e   rr_q;
  mem_src_e   head_src;
  logic [0:0] head_raw;
  logic       fifo_full;
  logic       fifo_empty;
  logic       handshake;
  logic       pop;
  logic       err_q;

  // rr_q remembers the last winner; on a tie the other source goes next.
  always_comb begin
    winner = SRC_INSTR;
    if (instr_req_i && data_req_i) begin
      if (DATA_PRIO != 0) begin
        winner = SRC_DATA;
      end else begin
        winner = (rr_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
      end
    end else if (data_req_i) begin
      winner = SRC_DATA;
    end
  end

  // Full masks the request even when a pop frees a slot this cycle.
  assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full;
  assign handshake = mem_req_o & mem_gnt_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '1;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (winner == SRC_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = handshake & (winner == SRC_INSTR);
  assign data_gnt_o  = handshake & (winner == SRC_DATA);

  miriscv_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .push_i  (handshake),
    .wdata_i (winner),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop      = mem_rvalid_i & ~fifo_empty;
  assign head_src = mem_src_e'(head_raw);

  assign instr_rvalid_o = pop & (head_src == SRC_INSTR);
  assign data_rvalid_o  = pop & (head_src == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rr_q <= SRC_INSTR;
    end else if (handshake) begin
      rr_q <= winner;
    end
  end

  // A response with nothing outstanding is a protocol violation; sticky.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      err_q <= 1'b0;
    end else if (mem_rvalid_i && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter: round-robin (index 0) and data-priority
// (index 1) instances share stimulus and are checked against a queue model.
module tb_miriscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        arstn;
  logic        ir, dr, dwe, g, rv;
  logic [31:0] ia, da, dwd, rd;
  logic [3:0]  dbe;

  logic        igt [2];
  logic        irv [2];
  logic        dgt [2];
  logic        drv [2];
  logic        mreq [2];
  logic        mwe [2];
  logic        err [2];
  logic [31:0] ird [2];
  logic [31:0] drd [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd [2];
  logic [3:0]  mbe [2];

  int ncmp = 0;
  int nerr = 0;

  // Model: list of outstanding issuers (1 = data), last winner, sticky error.
  int qd [2][2];
  int qn [2];
  bit last_d [2];
  bit merr [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    miriscv_mem_arbiter #(
      .OUTSTANDING (2),
      .DATA_PRIO   (k)
    ) u_dut (
      .clk_i          (clk),
      .arstn_i        (arstn),
      .instr_req_i    (ir),
      .instr_addr_i   (ia),
      .instr_gnt_o    (igt[k]),
      .instr_rvalid_o (irv[k]),
      .instr_rdata_o  (ird[k]),
      .data_req_i     (dr),
      .data_we_i      (dwe),
      .data_be_i      (dbe),
      .data_addr_i    (da),
      .data_wdata_i   (dwd),
      .data_gnt_o     (dgt[k]),
      .data_rvalid_o  (drv[k]),
      .data_rdata_o   (drd[k]),
      .mem_req_o      (mreq[k]),
      .mem_we_o       (mwe[k]),
      .mem_be_o       (mbe[k]),
      .mem_addr_o     (maddr[k]),
      .mem_wdata_o    (mwd[k]),
      .mem_gnt_i      (g),
      .mem_rvalid_i   (rv),
      .mem_rdata_i    (rd),
      .err_o          (err[k])
    );
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic model_check(input int k);
    bit full, ereq, wd, hs, pop;
    int head;
    full = (qn[k] == 2);
    ereq = (ir || dr) && !full;
    wd   = dr && (!ir || k == 1 || !last_d[k]);
    hs   = ereq && g;
    pop  = rv && (qn[k] > 0);
    head = pop ? qd[k][0] : 0;
    chk("mem_req", k, 32'(mreq[k]), 32'(ereq));
    if (ereq) begin
      chk("mem_addr", k, maddr[k], wd ? da : ia);
      chk("mem_we", k, 32'(mwe[k]), wd ? 32'(dwe) : 32'd0);
      chk("mem_be", k, 32'(mbe[k]), wd ? 32'(dbe) : 32'hF);
      chk("mem_wdata", k, mwd[k], wd ? dwd : 32'd0);
    end
    chk("instr_gnt", k, 32'(igt[k]), 32'(hs && !wd));
    chk("data_gnt", k, 32'(dgt[k]), 32'(hs && wd));
    chk("instr_rvalid", k, 32'(irv[k]), 32'(pop && head == 0));
    chk("data_rvalid", k, 32'(drv[k]), 32'(pop && head == 1));
    chk("instr_rdata", k, ird[k], rd);
    chk("data_rdata", k, drd[k], rd);
    chk("err", k, 32'(err[k]), 32'(merr[k]));
    if (rv && qn[k] == 0) merr[k] = 1'b1;
    if (pop) begin
      qd[k][0] = qd[k][1];
      qn[k]--;
    end
    if (hs) begin
      qd[k][qn[k]] = int'(wd);
      qn[k]++;
      last_d[k] = wd;
    end
  endtask

  task automatic tick(input logic i_r, input logic [31:0] i_a, input logic d_r, input logic d_we,
                      input logic [3:0] d_be, input logic [31:0] d_a, input logic [31:0] d_wd,
                      input logic m_g, input logic m_rv, input logic [31:0] m_rd);
    @(negedge clk);
    ir = i_r; ia = i_a; dr = d_r; dwe = d_we; dbe = d_be; da = d_a; dwd = d_wd;
    g = m_g; rv = m_rv; rd = m_rd;
    #1;
    for (int k = 0; k < 2; k++) model_check(k);
  endtask

  task automatic idle();
    tick(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, away from either clock edge.
  task automatic rst();
    @(negedge clk);
    #2;
    ir = 1'b0; dr = 1'b0; g = 1'b0; rv = 1'b0;
    arstn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_err", k, 32'(err[k]), 32'd0);
      chk("rst_req", k, 32'(mreq[k]), 32'd0);
      qn[k] = 0;
      last_d[k] = 1'b0;
      merr[k] = 1'b0;
    end
    @(negedge clk);
    arstn = 1'b1;
  endtask

  initial begin
    bit exp_d [4];
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
    ir = 0; dr = 0; dwe = 0; g = 0; rv = 0;
    ia = '0; da = '0; dwd = '0; rd = '0; dbe = '0;
    arstn = 1'b1;
    rst();
    idle();

    // Instruction fetch alone
    tick(1'b1, 32'h8000_0000, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("t1_igt", 1, 32'(igt[1]), 32'd1);
    tick(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_0013);
    chk("t1_irv", 1, 32'(irv[1]), 32'd1);
    chk("t1_ird", 1, ird[1], 32'h13);
    chk("t1_drv", 1, 32'(drv[1]), 32'd0);

    // Simultaneous fetch and store, data has priority
    tick(1'b1, 32'h100, 1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
    chk("t2_addr0", 1, maddr[1], 32'h2000);
    chk("t2_we0", 1, 32'(mwe[1]), 32'd1);
    chk("t2_dgt", 1, 32'(dgt[1]), 32'd1);
    tick(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("t2_addr1", 1, maddr[1], 32'h100);
    chk("t2_igt", 1, 32'(igt[1]), 32'd1);
    tick(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1111_2222);
    chk("t2_drv", 1, 32'(drv[1]), 32'd1);
    tick(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h3333_4444);
    chk("t2_irv", 1, 32'(irv[1]), 32'd1);

    // Round-robin alternation from reset
    rst();
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 32'h400 + 32'(c), 1'b1, 1'b0, 4'h3, 32'h800 + 32'(c), 32'd0, 1'b1, c > 0, 32'(c));
      chk("t3_rr_dgt", 0, 32'(dgt[0]), 32'(exp_d[c]));
      chk("t3_rr_igt", 0, 32'(igt[0]), 32'(!exp_d[c]));
    end

    // Randomized traffic; responses only when both instances have something pending
    rst();
    for (int n = 0; n < 300; n++) begin
      tick(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom,
           $urandom_range(0, 3) != 0, 1'($urandom) && qn[0] > 0 && qn[1] > 0, $urandom);
    end

    // Full FIFO masks the request, even on a pop cycle
    rst();
    tick(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    tick(1'b1, 32'h14, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    tick(1'b1, 32'h18, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("t4_full_req", 1, 32'(mreq[1]), 32'd0);
    chk("t4_full_gnt", 1, 32'(igt[1]), 32'd0);
    tick(1'b1, 32'h18, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h55);
    chk("t4_pop_req", 1, 32'(mreq[1]), 32'd0);
    tick(1'b1, 32'h18, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("t4_req_back", 1, 32'(mreq[1]), 32'd1);
    chk("t4_gnt_back", 1, 32'(igt[1]), 32'd1);

    // Reset with two in flight, then a stray response
    rst();
    tick(1'b0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h77);
    chk("t6_stray_irv", 1, 32'(irv[1]), 32'd0);
    chk("t6_stray_drv", 1, 32'(drv[1]), 32'd0);
    idle();
    chk("t6_err", 1, 32'(err[1]), 32'd1);
    idle();
    idle();
    chk("t6_err_sticky", 0, 32'(err[0]), 32'd1);
    rst();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
